syscall_print_ctrl: RTL and testbench

- Sequencer and arbiter for the data memory port, sitting between the pipeline MEM stage and datamem.
- On a print-string syscall (sys rising with regv==4), it stalls the pipeline and takes ownership of the datamem address/write port. It walks the null-terminated string word by word and streams bytes out over a valid/ready character interface.
- Replaces the simulation-only print loop with synthesizable, cycle-accurate behaviour.

---
 rtl/syscall_print_ctrl.sv | 115 +++++++++++
 tb/tb_syscall_print_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_print_ctrl.sv
// Print-string syscall engine: takes over the datamem port, walks a null-terminated
// string word by word and streams its bytes over a valid/ready character interface.
module syscall_print_ctrl #(
  parameter logic [31:0] SYS_PRINT = 32'd4,
  parameter logic [31:0] TEXT_LO   = 32'h0040_0000,
  parameter logic [31:0] TEXT_HI   = 32'h0040_0400,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys,
  input  logic [31:0] regv,
  input  logic [31:0] rega,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_memwrite,
  input  logic        cpu_memwrite8,
  output logic [31:0] mem_addr,
  output logic        mem_memwrite,
  output logic        mem_memwrite8,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int             CW   = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0]  MAXW = CW'(MAX_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EMIT, S_DONE} state_t;

  state_t          r_state;
  logic            r_sys_d;
  logic [31:0]     r_ptr;
  logic [31:0]     r_word;
  logic [1:0]      r_idx;
  logic [CW-1:0]   r_wcount;
  logic            r_overrun;

  logic            w_idle;
  logic            w_start;
  logic [7:0]      w_byte;
  logic            w_emit;

  assign w_idle  = (r_state == S_IDLE);
  assign w_start = sys && !r_sys_d && (regv == SYS_PRINT) &&
                   ((rega < TEXT_LO) || (rega > TEXT_HI));
  assign w_byte  = r_word[{r_idx, 3'b000} +: 8];
  assign w_emit  = (r_state == S_EMIT) && (w_byte != 8'h00);

  // The CPU sees datamem untouched while idle; the engine owns it otherwise.
  assign mem_addr      = w_idle ? cpu_addr : {r_ptr[31:2], 2'b00};
  assign mem_memwrite  = w_idle && cpu_memwrite;
  assign mem_memwrite8 = w_idle && cpu_memwrite8;

  assign stall      = !w_idle;
  assign busy       = !w_idle;
  assign done       = (r_state == S_DONE);
  assign char_valid = w_emit;
  assign char_data  = w_emit ? w_byte : 8'h00;
  assign overrun    = r_overrun;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_sys_d   <= 1'b0;
      r_ptr     <= '0;
      r_word    <= '0;
      r_idx     <= '0;
      r_wcount  <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_sys_d <= sys;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_ptr     <= {rega[31:2], 2'b00};
            r_wcount  <= '0;
            r_overrun <= 1'b0;
            r_state   <= S_READ;
          end
        end
        S_READ: begin
          r_word   <= mem_rdata;
          r_idx    <= '0;
          r_wcount <= r_wcount + 1'b1;
          r_ptr    <= r_ptr + 32'd4;
          r_state  <= S_EMIT;
        end
        S_EMIT: begin
          // A zero byte terminates without ever being presented to the consumer.
          if (w_byte == 8'h00) begin
            r_state <= S_DONE;
          end else if (char_ready) begin
            if (r_idx != 2'd3) begin
              r_idx <= r_idx + 1'b1;
            end else if (r_wcount == MAXW) begin
              r_overrun <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_print_ctrl.sv
// Bench for syscall_print_ctrl: directed and randomized prints checked against a
// string-walking reference model over a small bench-side RAM.
module tb_syscall_print_ctrl;

  localparam int MAXW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sys;
  logic [31:0] regv, rega, cpu_addr;
  logic        cpu_memwrite, cpu_memwrite8;
  logic [31:0] mem_addr, mem_rdata;
  logic        mem_memwrite, mem_memwrite8;
  logic        stall, char_valid, char_ready, busy, done, overrun;
  logic [7:0]  char_data;

  logic [31:0] ram [0:255];
  assign mem_rdata = ram[mem_addr[9:2]];

  syscall_print_ctrl #(.MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .sys(sys), .regv(regv), .rega(rega),
    .cpu_addr(cpu_addr), .cpu_memwrite(cpu_memwrite), .cpu_memwrite8(cpu_memwrite8),
    .mem_addr(mem_addr), .mem_memwrite(mem_memwrite), .mem_memwrite8(mem_memwrite8),
    .mem_rdata(mem_rdata), .stall(stall), .char_valid(char_valid), .char_data(char_data),
    .char_ready(char_ready), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected byte stream, overrun flag, stall cycles at full rate.
  logic [7:0] exp_q [$];
  bit         exp_ov;
  int         exp_cyc;

  task automatic model(input logic [31:0] a);
    logic [31:0] p, w;
    exp_q.delete();
    exp_ov  = 1'b0;
    exp_cyc = 1;
    p = {a[31:2], 2'b00};
    for (int wi = 0; wi < MAXW; wi++) begin
      exp_cyc++;
      w = ram[p[9:2]];
      for (int b = 0; b < 4; b++) begin
        exp_cyc++;
        if (w[8*b +: 8] == 8'h00) return;
        exp_q.push_back(w[8*b +: 8]);
      end
      p = p + 32'd4;
    end
    exp_ov = 1'b1;
  endtask

  // Monitor state, sampled on the falling edge.
  logic [7:0]  got_q [$];
  int          done_cnt, stall_cnt, wr_viol, addr_viol, stab_viol;
  logic [31:0] addr_lo, addr_hi;
  logic [7:0]  prev_data;
  bit          prev_hold, prev_done;
  logic [31:0] post_addr;
  logic        post_mw, post_stall;

  always @(negedge clk) begin
    if (char_valid && char_ready) got_q.push_back(char_data);
    if (done) done_cnt++;
    if (stall) begin
      stall_cnt++;
      if (mem_memwrite || mem_memwrite8) wr_viol++;
      if (mem_addr < addr_lo || mem_addr > addr_hi || mem_addr[1:0] != 2'b00) addr_viol++;
    end
    if (prev_hold && (!char_valid || char_data != prev_data)) stab_viol++;
    if (prev_done) begin
      post_addr  = mem_addr;
      post_mw    = mem_memwrite;
      post_stall = stall;
    end
    prev_hold = char_valid && !char_ready;
    prev_data = char_data;
    prev_done = done;
  end

  int rdy_mode;
  initial begin
    char_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       char_ready = 1'b1;
        1:       char_ready = ~char_ready;
        default: char_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic clear_mon(input logic [31:0] a);
    got_q.delete();
    done_cnt = 0; stall_cnt = 0; wr_viol = 0; addr_viol = 0; stab_viol = 0;
    prev_hold = 1'b0; prev_done = 1'b0;
    post_addr = 'x; post_mw = 1'bx; post_stall = 1'bx;
    addr_lo = {a[31:2], 2'b00};
    addr_hi = addr_lo + 32'(4 * MAXW);
  endtask

  task automatic run_print(input string tag, input logic [31:0] v, input logic [31:0] a,
                           input bit expect_go, input int hold);
    int n;
    clear_mon(a);
    if (expect_go) model(a);
    @(posedge clk); #1;
    sys = 1'b1; regv = v; rega = a;
    repeat (hold) @(posedge clk);
    #1 sys = 1'b0;
    if (expect_go) begin
      n = 0;
      while (done_cnt == 0 && n < 300) begin @(negedge clk); n++; end
      check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
      repeat (4) @(negedge clk);
      check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
      check({tag, "_nchars"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
        check({tag, "_char"}, (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxx_xxxx, 32'(exp_q[i]));
      check({tag, "_overrun"}, 32'(overrun), 32'(exp_ov));
      check({tag, "_wr_blocked"}, 32'(wr_viol), 32'd0);
      check({tag, "_addr_ptr"}, 32'(addr_viol), 32'd0);
      check({tag, "_stable"}, 32'(stab_viol), 32'd0);
      if (rdy_mode == 0) check({tag, "_stall_cyc"}, 32'(stall_cnt), 32'(exp_cyc));
      check({tag, "_post_stall"}, 32'(post_stall), 32'd0);
      check({tag, "_post_addr"}, post_addr, cpu_addr);
      check({tag, "_post_mw"}, 32'(post_mw), 32'(cpu_memwrite));
    end else begin
      repeat (20) @(negedge clk);
      check({tag, "_no_stall"}, 32'(stall_cnt), 32'd0);
      check({tag, "_no_chars"}, 32'(got_q.size()), 32'd0);
      check({tag, "_no_done"}, 32'(done_cnt), 32'd0);
    end
  endtask

  initial begin
    int n;
    logic [31:0] base, w;
    rst_n = 1'b0; sys = 1'b0; regv = '0; rega = '0;
    cpu_addr = 32'h0000_1234; cpu_memwrite = 1'b0; cpu_memwrite8 = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h00] = 32'h6C6C_6548;   // 0x00400800 "Hell"
    ram[8'h01] = 32'h0000_006F;   // "o"
    ram[8'h10] = 32'h4443_4241;   // 0x00400840, no terminator
    ram[8'h11] = 32'h4847_4645;
    ram[8'h12] = 32'h4C4B_4A49;
    ram[8'h20] = 32'h4141_4100;   // 0x00400880, empty string
    ram[8'hFF] = 32'h0021_4243;   // 0x003FFFFC

    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(char_valid), 32'd0);
    check("rst_data", 32'(char_data), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_passthru", mem_addr, cpu_addr);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_print("hello", 32'd4, 32'h0040_0800, 1'b1, 1);
    check("hello_stall9", 32'(stall_cnt), 32'd9);
    rdy_mode = 1;
    run_print("hello_toggle", 32'd4, 32'h0040_0800, 1'b1, 1);
    rdy_mode = 0;

    run_print("in_text", 32'd4, 32'h0040_0100, 1'b0, 1);
    run_print("text_hi", 32'd4, 32'h0040_0400, 1'b0, 1);
    run_print("regv1", 32'd1, 32'h0040_0800, 1'b0, 1);
    run_print("below_lo", 32'd4, 32'h003F_FFFF, 1'b1, 1);
    run_print("above_hi", 32'd4, 32'h0040_0401, 1'b1, 1);
    run_print("empty", 32'd4, 32'h0040_0880, 1'b1, 1);
    run_print("sys_held", 32'd4, 32'h0040_0800, 1'b1, 25);

    cpu_addr = 32'h0040_0900; cpu_memwrite = 1'b1; cpu_memwrite8 = 1'b1;
    run_print("cpu_wr", 32'd4, 32'h0040_0802, 1'b1, 1);
    cpu_memwrite = 1'b0; cpu_memwrite8 = 1'b0;

    run_print("overrun", 32'd4, 32'h0040_0840, 1'b1, 1);
    check("overrun_8chars", 32'(got_q.size()), 32'd8);
    run_print("ovr_ignored", 32'd1, 32'h0040_0840, 1'b0, 1);
    check("ovr_sticky", 32'(overrun), 32'd1);
    run_print("ovr_clear", 32'd4, 32'h0040_0800, 1'b1, 1);

    for (int k = 0; k < 8; k++) begin
      base = 32'h2000_0100 + 32'(k * 'h40);
      for (int wi = 0; wi < 3; wi++) begin
        for (int b = 0; b < 4; b++)
          w[8*b +: 8] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        ram[base[9:2] + 8'(wi)] = w;
      end
      rdy_mode = k % 3;
      run_print("rand", 32'd4, base + 32'($urandom_range(0, 3)), 1'b1, 1);
    end
    rdy_mode = 0;

    clear_mon(32'h0040_0800);
    @(posedge clk); #1 sys = 1'b1; regv = 32'd4; rega = 32'h0040_0800;
    @(posedge clk); #1 sys = 1'b0;
    n = 0;
    while (got_q.size() < 2 && n < 50) begin @(negedge clk); n++; end
    check("mid_emit_reached", 32'(got_q.size() >= 2), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(char_valid), 32'd0);
    check("arst_data", 32'(char_data), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_mw", 32'(mem_memwrite), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    n = got_q.size();
    repeat (10) @(negedge clk);
    check("arst_no_more", 32'(got_q.size()), 32'(n));
    check("arst_no_done", 32'(done_cnt), 32'd0);
    run_print("after_rst", 32'd4, 32'h0040_0800, 1'b1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
